// File: rtl/stream_demux1to2_8_if.sv
// Bundle of all non-clock signals of the 1-to-2 byte stream demultiplexer:
// the upstream handshake, both downstream handshakes, and the transfer counters.
interface stream_demux1to2_8_if #(
  parameter int CNT_W = 8
);

  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             s_sel;

  logic             m0_valid;
  logic             m0_ready;
  logic [7:0]       m0_data;
  logic             m1_valid;
  logic             m1_ready;
  logic [7:0]       m1_data;

  logic             cnt_clr;
  logic [CNT_W-1:0] m0_cnt;
  logic [CNT_W-1:0] m1_cnt;

  // Environment side: drives upstream data, downstream readies and the clear.
  modport master (
    output s_valid, s_data, s_sel, m0_ready, m1_ready, cnt_clr,
    input  s_ready, m0_valid, m0_data, m1_valid, m1_data, m0_cnt, m1_cnt
  );

  // Demultiplexer side.
  modport slave (
    input  s_valid, s_data, s_sel, m0_ready, m1_ready, cnt_clr,
    output s_ready, m0_valid, m0_data, m1_valid, m1_data, m0_cnt, m1_cnt
  );

endinterface

// File: rtl/stream_demux1to2_8.sv
// 1-to-2 byte stream demultiplexer. Every output port owns a private two-entry
// FIFO and a wrapping transfer counter. s_ready depends only on s_sel and the
// registered occupancy, so a stalled port never blocks the other one and no
// combinational path runs from a downstream ready back upstream.
module stream_demux1to2_8 #(
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  stream_demux1to2_8_if.slave   bus
);

  logic [1:0] mReady;
  logic [1:0] full;
  logic       sReady;
  logic       sFire;

  assign mReady = {bus.m1_ready, bus.m0_ready};

  for (genvar p = 0; p < 2; p++) begin : gPort
    logic [7:0]       mem_q [2];
    logic [7:0]       mem_d [2];
    logic             rdPtr_q;
    logic             rdPtr_d;
    logic             wrPtr_q;
    logic             wrPtr_d;
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             push;
    logic             pop;

    assign push = sFire && (bus.s_sel == 1'(p));
    assign pop  = (occ_q != 2'd0) && mReady[p];

    // Next FIFO and counter state from this port's push/pop and the clear.
    always_comb begin
      mem_d   = mem_q;
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      occ_d   = occ_q;
      cnt_d   = cnt_q;
      if (push) begin
        mem_d[wrPtr_q] = bus.s_data;
        wrPtr_d        = ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_d = ~rdPtr_q;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
      if (bus.cnt_clr) begin
        cnt_d = '0;
      end else if (pop) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Port state registers; reset empties the FIFO and discards its bytes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[0] <= 8'h00;
        mem_q[1] <= 8'h00;
        rdPtr_q  <= 1'b0;
        wrPtr_q  <= 1'b0;
        occ_q    <= 2'd0;
        cnt_q    <= '0;
      end else begin
        mem_q    <= mem_d;
        rdPtr_q  <= rdPtr_d;
        wrPtr_q  <= wrPtr_d;
        occ_q    <= occ_d;
        cnt_q    <= cnt_d;
      end
    end
  end

  assign full   = {gPort[1].occ_q == 2'd2, gPort[0].occ_q == 2'd2};
  assign sReady = rst_n && !full[bus.s_sel];
  assign sFire  = bus.s_valid && sReady;

  assign bus.s_ready  = sReady;
  assign bus.m0_valid = (gPort[0].occ_q != 2'd0);
  assign bus.m1_valid = (gPort[1].occ_q != 2'd0);
  assign bus.m0_data  = gPort[0].mem_q[gPort[0].rdPtr_q];
  assign bus.m1_data  = gPort[1].mem_q[gPort[1].rdPtr_q];
  assign bus.m0_cnt   = gPort[0].cnt_q;
  assign bus.m1_cnt   = gPort[1].cnt_q;

endmodule
